// File: rtl/bit_serializer_pkg.sv
// Shared types and default parameters for the parallel-to-serial front end.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_GAP   = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO; flush empties it and wins over push/pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_c    = (count_q == CW'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign rd_data_c = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Push is refused when full even if a pop frees a slot in the same cycle.
  always_comb begin
    push_ok  = push & ~full_c & ~flush;
    pop_ok   = pop & ~empty_c & ~flush;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: buffers words in a FIFO and shifts each out
// one bit per clock, with an optional idle gap between words.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_DEPTH,
  parameter int unsigned GAP_CYCLES = DEF_GAP,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_first_q, ser_first_d;
  logic             ser_last_q, ser_last_d;

  logic             pop_c;
  logic             fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic [CW-1:0]    fifo_count;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid & in_ready),
    .pop       (pop_c),
    .flush     (flush),
    .wr_data   (in_word),
    .rd_data_c (fifo_rd_data),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty),
    .count     (fifo_count)
  );

  // Held low during reset so the source never sees a ready it cannot use.
  assign in_ready = ~reset & ~fifo_full;
  assign busy     = (fifo_count != '0) || (state_q != IDLE);

  assign ser_data  = ser_data_q;
  assign ser_valid = ser_valid_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ser_data_d  = 1'b0;
    ser_valid_d = 1'b0;
    ser_first_d = 1'b0;
    ser_last_d  = 1'b0;
    pop_c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        pop_c = ~fifo_empty;
      end
      SHIFT: begin
        if (bit_cnt_q != BCW'(WIDTH - 1)) begin
          ser_data_d  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
          shreg_d     = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          bit_cnt_d   = bit_cnt_q + BCW'(1);
          ser_valid_d = 1'b1;
          ser_last_d  = (bit_cnt_d == BCW'(WIDTH - 1));
        end else if (GAP_CYCLES != 0) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else if (!fifo_empty) begin
          pop_c = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q == GCW'(GAP_CYCLES - 1)) begin
          if (!fifo_empty) begin
            pop_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A pop loads the head word and presents its first bit right after the edge.
    if (pop_c) begin
      state_d     = SHIFT;
      bit_cnt_d   = '0;
      ser_data_d  = LSB_FIRST ? fifo_rd_data[0] : fifo_rd_data[WIDTH-1];
      shreg_d     = LSB_FIRST ? (fifo_rd_data >> 1) : (fifo_rd_data << 1);
      ser_valid_d = 1'b1;
      ser_first_d = 1'b1;
      ser_last_d  = (WIDTH == 1);
    end

    if (flush) begin
      pop_c       = 1'b0;
      state_d     = IDLE;
      bit_cnt_d   = '0;
      gap_cnt_d   = '0;
      ser_data_d  = 1'b0;
      ser_valid_d = 1'b0;
      ser_first_d = 1'b0;
      ser_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_data_q  <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three configurations share one stimulus stream and
// are scored against an ordered word queue per configuration.
module tb_bit_serializer;

  localparam int unsigned W  = 8;
  localparam int unsigned IW = $clog2(W);
  // Instance 0: gap 1, LSB first. Instance 1: gap 0, LSB first. Instance 2: gap 1, MSB first.
  localparam logic [2:0] LSB_MASK = 3'b011;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_word = '0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   in_ready, ser_data, ser_valid, ser_first, ser_last, busy;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] acc_q [3][$];
  logic [W-1:0] asm_w [3];
  int           pos   [3];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .FIFO_DEPTH(4), .GAP_CYCLES(1), .LSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready[0]),
    .flush(flush), .ser_data(ser_data[0]), .ser_valid(ser_valid[0]), .ser_first(ser_first[0]),
    .ser_last(ser_last[0]), .busy(busy[0]));

  bit_serializer #(.WIDTH(W), .FIFO_DEPTH(4), .GAP_CYCLES(0), .LSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready[1]),
    .flush(flush), .ser_data(ser_data[1]), .ser_valid(ser_valid[1]), .ser_first(ser_first[1]),
    .ser_last(ser_last[1]), .busy(busy[1]));

  bit_serializer #(.WIDTH(W), .FIFO_DEPTH(4), .GAP_CYCLES(1), .LSB_FIRST(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready[2]),
    .flush(flush), .ser_data(ser_data[2]), .ser_valid(ser_valid[2]), .ser_first(ser_first[2]),
    .ser_last(ser_last[2]), .busy(busy[2]));

  // Reassembles serial words per instance and matches them in order with accepted words.
  task automatic monitor();
    logic [W-1:0] exp_w;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (ser_valid[2'(k)]) begin
          if (pos[k] == 0) asm_w[k] = '0;
          if (LSB_MASK[2'(k)]) asm_w[k] = asm_w[k] | (W'(ser_data[2'(k)]) << pos[k]);
          else                 asm_w[k] = asm_w[k] | (W'(ser_data[2'(k)]) << (W - 1 - pos[k]));
          checks++;
          if ({ser_first[2'(k)], ser_last[2'(k)]} !== {pos[k] == 0, pos[k] == W - 1}) begin
            errors++;
            $display("FAIL flags dut%0d bit %0d: first/last=%b%b expected %b%b", k, pos[k],
                     ser_first[2'(k)], ser_last[2'(k)], pos[k] == 0, pos[k] == W - 1);
          end
          if (pos[k] == W - 1) begin
            checks++;
            if (acc_q[k].size() == 0) begin
              errors++;
              $display("FAIL word dut%0d: got %h, expected no word", k, asm_w[k]);
            end else begin
              exp_w = acc_q[k].pop_front();
              if (asm_w[k] !== exp_w) begin
                errors++;
                $display("FAIL word dut%0d: got %h expected %h", k, asm_w[k], exp_w);
              end
            end
            pos[k] = 0;
          end else begin
            pos[k]++;
          end
        end else begin
          checks++;
          if ({ser_data[2'(k)], ser_first[2'(k)], ser_last[2'(k)]} !== 3'b000) begin
            errors++;
            $display("FAIL idle dut%0d: data/first/last=%b%b%b expected 000", k,
                     ser_data[2'(k)], ser_first[2'(k)], ser_last[2'(k)]);
          end
        end
        if (in_valid && in_ready[2'(k)] && !flush && !reset) acc_q[k].push_back(in_word);
        if (flush || reset) begin
          acc_q[k].delete();
          pos[k] = 0;
        end
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (busy == 3'b000) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ser_valid, ser_data, ser_first, ser_last, busy, in_ready} !== 18'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {ser_valid, ser_data, ser_first, ser_last, busy, in_ready});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy} !== 6'b111_000) begin
      errors++;
      $display("FAIL reset_release: in_ready/busy=%b expected 111000", {in_ready, busy});
    end
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    bit ok;
    w = 8'h55;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_idle: busy=%b expected 000", busy); end
    @(posedge clk); #1;
    in_word = w; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 3'b111) begin errors++; $display("FAIL single_busy: got %b expected 111", busy); end
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (c <= 8) begin
        if ({ser_valid[0], ser_data[0], ser_first[0], ser_last[0]} !==
            {1'b1, 1'(w >> (c - 1)), c == 1, c == 8}) begin
          errors++;
          $display("FAIL single_bit%0d: v/d/f/l=%b%b%b%b expected %b%b%b%b", c, ser_valid[0],
                   ser_data[0], ser_first[0], ser_last[0], 1'b1, 1'(w >> (c - 1)), c == 1, c == 8);
        end
        checks++;
        if (ser_data[2] !== 1'(w >> (8 - c))) begin
          errors++;
          $display("FAIL single_msb_bit%0d: got %b expected %b", c, ser_data[2], 1'(w >> (8 - c)));
        end
      end else if (c == 9) begin
        if ({ser_valid[0], ser_data[0], busy[0]} !== 3'b001) begin
          errors++;
          $display("FAIL single_gap: v/d/busy=%b expected 001", {ser_valid[0], ser_data[0], busy[0]});
        end
      end else if (busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL single_done: busy=%b expected 0", busy[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    logic        e0v, e0d, e1v, e1d;
    bit          ok;
    s = {8'h81, 8'hC3};
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_idle: busy=%b expected 000", busy); end
    @(posedge clk); #1;
    in_word = 8'hC3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_word = 8'h81;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      e1v = (c <= 16);
      e1d = e1v ? 1'(s >> (c - 1)) : 1'b0;
      e0v = (c != 9);
      e0d = (c <= 8) ? 1'(s >> (c - 1)) : (c >= 10) ? 1'(s >> (c - 2)) : 1'b0;
      checks++;
      if ({ser_valid[1], ser_data[1]} !== {e1v, e1d}) begin
        errors++;
        $display("FAIL b2b_nogap c%0d: v/d=%b%b expected %b%b", c, ser_valid[1], ser_data[1], e1v, e1d);
      end
      checks++;
      if ({ser_valid[0], ser_data[0]} !== {e0v, e0d}) begin
        errors++;
        $display("FAIL b2b_gap c%0d: v/d=%b%b expected %b%b", c, ser_valid[0], ser_data[0], e0v, e0d);
      end
    end
  endtask

  task automatic test_msb_first();
    logic [15:0] s;
    logic        ev, ed;
    bit          ok;
    s = {8'h81, 8'h03};
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL msb_idle: busy=%b expected 000", busy); end
    @(posedge clk); #1;
    in_word = 8'h81; in_valid = 1'b1;
    @(posedge clk); #1;
    in_word = 8'h03;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      ev = (c != 9);
      ed = (c <= 8) ? 1'(s >> (16 - c)) : (c >= 10) ? 1'(s >> (17 - c)) : 1'b0;
      checks++;
      if ({ser_valid[2], ser_data[2]} !== {ev, ed}) begin
        errors++;
        $display("FAIL msb c%0d: v/d=%b%b expected %b%b", c, ser_valid[2], ser_data[2], ev, ed);
      end
    end
  endtask

  task automatic test_full_throttle();
    logic [W-1:0] w [6];
    int           acc_cyc [6];
    int           idx, cyc;
    logic         rdy;
    bit           ok;
    for (int i = 0; i < 6; i++) w[i] = W'($urandom);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_idle: busy=%b expected 000", busy); end
    idx = 0; cyc = 0;
    @(posedge clk); #1;
    in_word = w[0]; in_valid = 1'b1;
    while (idx < 6 && cyc < 200) begin
      @(negedge clk);
      rdy = in_ready[0];
      @(posedge clk);
      cyc++;
      if (rdy) begin acc_cyc[idx] = cyc; idx++; end
      #1;
      if (idx < 6) in_word = w[idx]; else in_valid = 1'b0;
      if (rdy && idx == 5) begin
        checks++;
        if (in_ready[0] !== 1'b0) begin
          errors++;
          $display("FAIL full_ready_drop: in_ready=%b expected 0", in_ready[0]);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 6) begin errors++; $display("FAIL full_accepts: got %0d expected 6", idx); end
    else begin
      checks++;
      if (acc_cyc[4] - acc_cyc[0] != 4) begin
        errors++;
        $display("FAIL full_first5: span %0d expected 4", acc_cyc[4] - acc_cyc[0]);
      end
      // Next slot opens when word 1 is popped after word 0 (8 bits) and one gap cycle.
      checks++;
      if (acc_cyc[5] - acc_cyc[4] != 7) begin
        errors++;
        $display("FAIL full_sixth: wait %0d expected 7", acc_cyc[5] - acc_cyc[4]);
      end
    end
    wait_idle(ok);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (!ok || acc_q[k].size() != 0) begin
        errors++;
        $display("FAIL full_drain dut%0d: pending=%0d expected 0", k, acc_q[k].size());
      end
    end
  endtask

  task automatic test_flush();
    int  seen;
    bit  ok;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flush_idle: busy=%b expected 000", busy); end
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_word = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, ser_valid[0]} !== 4'b1111) begin
      errors++;
      $display("FAIL flush_pre: busy/valid=%b expected 1111", {busy, ser_valid[0]});
    end
    flush = 1'b1; in_valid = 1'b1; in_word = W'($urandom);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({ser_valid, busy, in_ready} !== 9'b000_000_111) begin
      errors++;
      $display("FAIL flush_post: valid/busy/ready=%b expected 000000111", {ser_valid, busy, in_ready});
    end
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ser_valid != 3'b000) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_residue: %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_reset_mid();
    int seen;
    bit ok;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_idle: busy=%b expected 000", busy); end
    @(posedge clk); #1;
    in_word = 8'h55; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) @(posedge clk);
    #1;
    checks++;
    if (ser_valid[0] !== 1'b1) begin errors++; $display("FAIL rst_midword: valid=%b expected 1", ser_valid[0]); end
    reset = 1'b1;
    #1;
    checks++;
    if ({ser_valid, ser_data, ser_first, ser_last, busy, in_ready} !== 18'b0) begin
      errors++;
      $display("FAIL rst_async: got %b expected all zero",
               {ser_valid, ser_data, ser_first, ser_last, busy, in_ready});
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy} !== 6'b111_000) begin
      errors++;
      $display("FAIL rst_release: in_ready/busy=%b expected 111000", {in_ready, busy});
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ser_valid != 3'b000) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_resume: %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_word  = W'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle(ok);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (!ok || acc_q[k].size() != 0) begin
        errors++;
        $display("FAIL random_drain dut%0d: pending=%0d expected 0", k, acc_q[k].size());
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      pos[k]   = 0;
      asm_w[k] = '0;
    end
    fork
      monitor();
    join_none
    fork
      begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_msb_first();
    test_full_throttle();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
